// File: rtl/mvu_pe_simd_xnor_acc.sv
// Binary SIMD PE: XNOR-popcount per beat, accumulated over SF folds, 2-stage valid/ready pipeline.
// Define MVU_XNOR_BIPOLAR_EN to emit the signed {-1,+1} dot product instead of the popcount sum.
module mvu_pe_simd_xnor_acc #(
  parameter int unsigned SIMD = 8,
  parameter int unsigned SF   = 4,
  parameter int unsigned TO   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_v,
  output logic            in_rdy,
  input  logic [SIMD-1:0] in_act,
  input  logic [SIMD-1:0] in_wgt,
  output logic            out_v,
  input  logic            out_rdy,
  output logic [TO-1:0]   out
);

  localparam int unsigned PcW  = $clog2(SIMD + 1);
  localparam int unsigned CntW = (SF > 1) ? $clog2(SF) : 1;
`ifdef MVU_XNOR_BIPOLAR_EN
  localparam int unsigned MinTo = $clog2(SIMD * SF + 1) + 1;
`else
  localparam int unsigned MinTo = $clog2(SIMD * SF + 1);
`endif

  generate
    if (SIMD < 1 || SF < 1) begin : g_param_check
      $error("mvu_pe_simd_xnor_acc: SIMD and SF must be >= 1");
    end
    if (TO < MinTo) begin : g_width_check
      $error("mvu_pe_simd_xnor_acc: TO too narrow for SIMD*SF result");
    end
  endgenerate

  logic [SIMD-1:0] match;
  logic [PcW-1:0]  pc_d, pc_q;
  logic            pc_v_q;
  logic [TO-1:0]   acc_d, acc_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic [TO-1:0]   out_d, out_q;
  logic            out_v_d, out_v_q;
  logic            adv;
  logic            last;
  logic [TO-1:0]   sum;
  logic [TO-1:0]   res;

  // Whole pipeline freezes only when a held result is not being taken.
  assign adv    = !(out_v_q && !out_rdy);
  assign in_rdy = adv;
  assign out_v  = out_v_q;
  assign out    = out_q;

  assign match = ~(in_act ^ in_wgt);

  always_comb begin
    pc_d = '0;
    for (int unsigned i = 0; i < SIMD; i++) begin
      pc_d = pc_d + PcW'(match[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= '0;
      pc_v_q <= 1'b0;
    end else if (adv) begin
      pc_q   <= pc_d;
      pc_v_q <= in_v;
    end
  end

  assign last = (cnt_q == CntW'(SF - 1));
  assign sum  = acc_q + TO'(pc_q);
`ifdef MVU_XNOR_BIPOLAR_EN
  // Matches minus mismatches: 2*matches - total lanes, two's complement.
  assign res  = (sum << 1) - TO'(SIMD * SF);
`else
  assign res  = sum;
`endif

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    out_v_d = out_v_q;
    if (out_rdy) begin
      out_v_d = 1'b0;
    end
    if (adv && pc_v_q) begin
      if (last) begin
        out_d   = res;
        out_v_d = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      out_v_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      out_v_q <= out_v_d;
    end
  end

endmodule

// File: tb/tb_mvu_pe_simd_xnor_acc.sv
// Scoreboard bench for mvu_pe_simd_xnor_acc: SF=4 main instance plus an SF=1 instance.
module tb_mvu_pe_simd_xnor_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_v;
  logic [7:0]  in_act, in_wgt;
  logic        out_rdy;
  logic        in_rdy, out_v;
  logic [15:0] out;
  logic        in_rdy1, out_v1;
  logic [15:0] out1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  mvu_pe_simd_xnor_acc #(.SIMD(8), .SF(4), .TO(16)) dut (
    .clk(clk), .rst(rst), .in_v(in_v), .in_rdy(in_rdy), .in_act(in_act), .in_wgt(in_wgt),
    .out_v(out_v), .out_rdy(out_rdy), .out(out)
  );

  mvu_pe_simd_xnor_acc #(.SIMD(8), .SF(1), .TO(16)) dut_sf1 (
    .clk(clk), .rst(rst), .in_v(in_v), .in_rdy(in_rdy1), .in_act(in_act), .in_wgt(in_wgt),
    .out_v(out_v1), .out_rdy(1'b1), .out(out1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pop8(input logic [7:0] a, input logic [7:0] w);
    logic [7:0] m;
    int n;
    m = ~(a ^ w);
    n = 0;
    for (int i = 0; i < 8; i++) n += int'(m[i]);
    return n;
  endfunction

  function automatic logic [15:0] fold_res(input int s, input int lanes);
`ifdef MVU_XNOR_BIPOLAR_EN
    return 16'(2 * s - lanes);
`else
    return 16'(s + 0 * lanes);
`endif
  endfunction

  // Reference model: accumulates accepted beats and queues each completed fold.
  logic [15:0] exp_q[$];
  int m_acc, m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_acc = 0;
      m_cnt = 0;
      exp_q.delete();
    end else if (in_v && in_rdy) begin
      m_acc += pop8(in_act, in_wgt);
      m_cnt++;
      if (m_cnt == 4) begin
        exp_q.push_back(fold_res(m_acc, 32));
        m_acc = 0;
        m_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_v && out_rdy) begin
      if (exp_q.size() == 0) check_eq("spurious out_v", 32'(out_v), 32'd0);
      else check_eq("result", 32'(out), 32'(exp_q.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] w);
    in_v   = 1'b1;
    in_act = a;
    in_wgt = w;
    step();
  endtask

  logic [7:0] ra[8], rw[8];
  int nb, guard;

  initial begin
    rst = 1'b1; in_v = 1'b0; in_act = '0; in_wgt = '0; out_rdy = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    check_eq("reset in_rdy", 32'(in_rdy), 32'd1);
    check_eq("reset out_v", 32'(out_v), 32'd0);
    check_eq("reset out", 32'(out), 32'd0);

    // All-match fold and its latency
    for (int i = 0; i < 4; i++) beat(8'hFF, 8'hFF);
    in_v = 1'b0;
    check_eq("latency t+1 out_v", 32'(out_v), 32'd0);
    step();
    check_eq("latency t+2 out_v", 32'(out_v), 32'd1);
    check_eq("latency t+2 out", 32'(out), 32'(fold_res(32, 32)));
    step();
    check_eq("one-cycle out_v", 32'(out_v), 32'd0);
    check_eq("out held", 32'(out), 32'(fold_res(32, 32)));

    // No-match fold, then a fold with bubbles between beats
    for (int i = 0; i < 4; i++) beat(8'hAA, 8'h55);
    for (int i = 0; i < 4; i++) begin
      beat(8'h0F, 8'h0F);
      in_v = 1'b0;
      step();
    end
    step(); step(); step();
    check_eq("bubble fold out", 32'(out), 32'(fold_res(32, 32)));

    // Backpressure: fold A held while fold B waits
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) beat(8'hFF, 8'hFF);
    check_eq("b1 in_rdy", 32'(in_rdy), 32'd1);
    beat(8'hF0, 8'h00);
    step();
    check_eq("stall in_rdy", 32'(in_rdy), 32'd0);
    check_eq("stall out_v", 32'(out_v), 32'd1);
    check_eq("stall out", 32'(out), 32'(fold_res(32, 32)));
    step(); step();
    check_eq("stall out stable", 32'(out), 32'(fold_res(32, 32)));
    check_eq("stall in_rdy hold", 32'(in_rdy), 32'd0);
    out_rdy = 1'b1;
    nb = 1;
    guard = 0;
    while (nb < 4 && guard < 20) begin
      #0;
      if (in_rdy) nb++;
      step();
      guard++;
    end
    check_eq("fold B beats accepted", 32'(nb), 32'd4);
    in_v = 1'b0;
    step(); step(); step();
    check_eq("fold B out", 32'(out), 32'(fold_res(16, 32)));

    // SF=1 instance: one result per beat, back to back
    for (int k = 0; k < 8; k++) begin
      ra[k] = 8'($urandom);
      rw[k] = 8'($urandom);
    end
    for (int k = 0; k < 8; k++) begin
      beat(ra[k], rw[k]);
      if (k >= 1) begin
        check_eq("sf1 out_v", 32'(out_v1), 32'd1);
        check_eq("sf1 out", 32'(out1), 32'(fold_res(pop8(ra[k-1], rw[k-1]), 8)));
      end
    end
    in_v = 1'b0;
    step();
    check_eq("sf1 last out", 32'(out1), 32'(fold_res(pop8(ra[7], rw[7]), 8)));
    step(); step(); step();

    // Asynchronous reset with a held result, no clock edge involved
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) beat(8'hFF, 8'hFF);
    in_v = 1'b0;
    step();
    check_eq("pre-reset out_v", 32'(out_v), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("async out", 32'(out), 32'd0);
    check_eq("async out_v", 32'(out_v), 32'd0);
    rst = 1'b0;
    out_rdy = 1'b1;
    #0;
    check_eq("post-reset in_rdy", 32'(in_rdy), 32'd1);
    step();

    // Reset mid-fold discards the partial sum
    beat(8'hFF, 8'hFF);
    beat(8'hFF, 8'hFF);
    in_v = 1'b0;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    step();
    for (int i = 0; i < 4; i++) beat(8'hFF, 8'hFF);
    in_v = 1'b0;
    step();
    check_eq("restart out", 32'(out), 32'(fold_res(32, 32)));
    step(); step(); step();

    check_eq("pending results", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
